mul16_seq: RTL and testbench

//   Sequential unsigned 16x16->32 shift-and-add multiplier for the lab ALU path.

---
 rtl/mul16_seq_pkg.sv | 13 +
 rtl/mul16_seq_add16.sv | 21 ++
 rtl/mul16_seq.sv | 86 ++++++++
 tb/tb_mul16_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mul16_seq_pkg.sv
// rtl/mul16_seq_pkg.sv - shared state encoding and step count for sequential ALU blocks
package mul16_seq_pkg;

  localparam int WIDTH     = 16;
  localparam int MUL_STEPS = WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mul16_seq_add16.sv
// rtl/mul16_seq_add16.sv - 16-bit ripple-carry adder, the multiplier's single adder
module add16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] z,
  output logic        cout
);

  logic [16:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign z[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[16];

endmodule

// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - sequential unsigned 16x16->32 shift-and-add multiplier
module mul16_seq
  import mul16_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  state_t      state;
  logic [15:0] mcand;
  logic [31:0] acc;
  logic [3:0]  count;

  logic [15:0] addend;
  logic [15:0] sum;
  logic        carry;
  logic [31:0] acc_next;

  assign addend = acc[0] ? mcand : 16'h0000;

  add16 u_add16 (
    .x    (acc[31:16]),
    .y    (addend),
    .cin  (1'b0),
    .z    (sum),
    .cout (carry)
  );

  // The carry lands in bit 31 after the shift, so no product bit is ever lost.
  assign acc_next = {carry, sum, acc[15:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mcand   <= 16'h0000;
      acc     <= 32'h0;
      count   <= 4'h0;
      product <= 32'h0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {16'h0000, b};
            count <= 4'h0;
            state <= S_RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          count <= count + 4'h1;
          if (count == 4'(MUL_STEPS - 1)) begin
            product <= acc_next;
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul16_seq.sv
// tb/tb_mul16_seq.sv - scoreboard bench for mul16_seq with directed vectors
module tb_mul16_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int n_done   = 0;
  int cyc      = 0;
  int acc_prev = 0;
  int acc_last = 0;

  logic [31:0] exp_q[$];

  mul16_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Acceptance log: ready/start seen here are the pre-edge values.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && ready && start) begin
      acc_prev = acc_last;
      acc_last = cyc;
    end
  end

  // Monitor: every done pulse consumes one expected product.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("product", product, e);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic run_mul(input logic [15:0] x, input logic [15:0] y, input logic [31:0] e);
    wait_ready();
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    exp_q.push_back(e); n_pushed++;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      check("ready_run", {31'd0, ready}, 32'd0);
      @(negedge clk);
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("ready_after", {31'd0, ready}, 32'd1);
    check("done_clear", {31'd0, done}, 32'd0);
    check("product_hold", product, e);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
    #2;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", product, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    run_mul(16'h0003, 16'h0005, 32'h0000000F);

    // Asynchronous reset mid-cycle clears a held product immediately.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_product", product, 32'h0);
    check("arst_ready", {31'd0, ready}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_mul(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run_mul(16'h0000, 16'h1234, 32'h00000000);
    run_mul(16'h1234, 16'h0001, 32'h00001234);
    run_mul(16'h00FF, 16'h0101, 32'h0000FFFF);

    // start held high with operands changing every cycle.
    wait_ready();
    @(negedge clk);
    start = 1'b1; a = 16'h0007; b = 16'h0009;
    exp_q.push_back(32'h0000003F); n_pushed++;
    exp_q.push_back(32'h00000006); n_pushed++;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 18) begin
        a = 16'h0002; b = 16'h0003;
      end else begin
        a = 16'hA5A5 ^ 16'(i); b = 16'h5A5A + 16'(i);
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("accept_spacing", 32'(acc_last - acc_prev), 32'd18);
    check("busy_second", {31'd0, busy}, 32'd1);
    wait_ready();

    // Reset during RUN aborts the operation without a done pulse.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_product", product, 32'h0);
    repeat (20) @(negedge clk);
    check("abort_no_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    run_mul(16'h0100, 16'h0100, 32'h00010000);

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
